// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a byte stream into little-endian 32-bit words
// and writes them at byte addresses 0, 4, 8, ... while holding the core in reset.
module imem_loader #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] num_words,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        core_hold,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  fsm_state
);

    // Handshake: a byte transfers on a rising edge where byte_valid && byte_ready;
    // byte_ready is a registered function of state only and never looks at byte_valid.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] word_q;
    logic [1:0]  idx;
    logic [15:0] count;
    logic [15:0] words_done;
    logic        count_ok;

    assign count_ok  = (num_words != 16'd0) && (num_words <= 16'(MEM_WORDS));
    assign mem_wdata = word_q;
    assign fsm_state = state;

    // Outputs are registered alongside the next state so they track state exactly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            word_q     <= 32'd0;
            idx        <= 2'd0;
            count      <= 16'd0;
            words_done <= 16'd0;
            mem_addr   <= 32'd0;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            core_hold  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            done   <= 1'b0;
            error  <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (count_ok) begin
                            count      <= num_words;
                            mem_addr   <= 32'd0;
                            idx        <= 2'd0;
                            words_done <= 16'd0;
                            state      <= COLLECT;
                            byte_ready <= 1'b1;
                            core_hold  <= 1'b1;
                            busy       <= 1'b1;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (byte_valid && byte_ready) begin
                        word_q[{idx, 3'b000} +: 8] <= byte_in;
                        if (idx == 2'd3) begin
                            idx        <= 2'd0;
                            state      <= WRITE;
                            byte_ready <= 1'b0;
                            mem_we     <= 1'b1;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                WRITE: begin
                    words_done <= words_done + 16'd1;
                    if (words_done + 16'd1 == count) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        mem_addr   <= mem_addr + 32'd4;
                        state      <= COLLECT;
                        byte_ready <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    core_hold <= 1'b0;
                    busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized bench for imem_loader, checked against a byte-queue model
// of the expected word writes.
module tb_imem_loader;

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] num_words;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  fsm_state;

    imem_loader #(.MEM_WORDS(64)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .num_words  (num_words),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_hold  (core_hold),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .fsm_state  (fsm_state)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // monitor: cumulative counts and observed writes, sampled on the falling edge
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    int done_cnt = 0, done_cyc = 0, err_cnt = 0, err_cyc = 0, hold_cnt = 0;

    always @(negedge clock) begin
        if (mem_we === 1'b1) begin
            got_addr.push_back(mem_addr);
            got_data.push_back(mem_wdata);
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (error === 1'b1) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (core_hold === 1'b1) hold_cnt++;
    end

    // reference model: expected writes from the byte stream
    logic [7:0]  bq[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    int checks = 0;
    int errors = 0;
    int base_we, base_done, base_err, base_hold, c0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build_model();
        exp_addr_q.delete();
        exp_data_q.delete();
        for (int i = 0; i < bq.size() / 4; i++) begin
            exp_addr_q.push_back(32'(i * 4));
            exp_data_q.push_back(32'(bq[4*i]) + (32'(bq[4*i+1]) << 8)
                                 + (32'(bq[4*i+2]) << 16) + (32'(bq[4*i+3]) << 24));
        end
    endtask

    task automatic fill_random(input int n);
        bq.delete();
        for (int k = 0; k < 4 * n; k++) bq.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic snapshot();
        base_we   = got_addr.size();
        base_done = done_cnt;
        base_err  = err_cnt;
        base_hold = hold_cnt;
        c0        = cyc;
    endtask

    // driver tasks
    task automatic send_byte(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        for (int t = 0; t < 16; t++) begin
            if (byte_ready === 1'b1) break;
            @(negedge clock);
        end
        check("ready_before_accept", 32'(byte_ready), 32'd1);
        @(negedge clock);
        byte_valid = 1'b0;
    endtask

    task automatic send_stream(input int gap);
        for (int k = 0; k < bq.size(); k++) begin
            send_byte(bq[k]);
            if (k != bq.size() - 1) begin
                for (int g = 0; g < gap; g++) begin
                    if (k % 4 != 3) begin
                        check("stall_ready", 32'(byte_ready), 32'd1);
                        check("stall_no_we", 32'(mem_we), 32'd0);
                    end
                    @(negedge clock);
                end
            end
        end
    endtask

    task automatic do_start(input int n);
        start     = 1'b1;
        num_words = 16'(n);
        @(negedge clock);
        start     = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 1000; t++) begin
            if (core_hold === 1'b0) break;
            @(negedge clock);
        end
        check("idle_reached", 32'(core_hold), 32'd0);
    endtask

    task automatic compare_writes(input string tag);
        int n;
        n = got_addr.size() - base_we;
        check({tag, "_write_count"}, 32'(n), 32'(exp_addr_q.size()));
        for (int i = 0; i < n && i < exp_addr_q.size(); i++) begin
            check({tag, "_addr"}, got_addr[base_we+i], exp_addr_q[i]);
            check({tag, "_data"}, got_data[base_we+i], exp_data_q[i]);
        end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        num_words  = 16'd0;
        byte_in    = 8'd0;
        byte_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // reset state
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_core_hold", 32'(core_hold), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);

        // directed 2-word load, back-to-back
        bq = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        build_model();
        check("model_word0", exp_data_q[0], 32'h0000_0013);
        check("model_word1", exp_data_q[1], 32'h0010_0093);
        snapshot();
        do_start(2);
        send_stream(0);
        wait_idle();
        compare_writes("b2b");
        check("b2b_done_count", 32'(done_cnt - base_done), 32'd1);
        check("b2b_done_cycle", 32'(done_cyc - c0), 32'd11);
        check("b2b_hold_cycles", 32'(hold_cnt - base_hold), 32'd11);

        // same load with 3-cycle stalls between bytes
        snapshot();
        do_start(2);
        send_stream(3);
        wait_idle();
        compare_writes("stall");
        check("stall_done_count", 32'(done_cnt - base_done), 32'd1);

        // illegal counts
        for (int r = 0; r < 2; r++) begin
            snapshot();
            do_start(r == 0 ? 0 : 65);
            repeat (3) @(negedge clock);
            check("illegal_error_count", 32'(err_cnt - base_err), 32'd1);
            check("illegal_error_cycle", 32'(err_cyc - c0), 32'd1);
            check("illegal_no_write", 32'(got_addr.size() - base_we), 32'd0);
            check("illegal_no_hold", 32'(hold_cnt - base_hold), 32'd0);
        end

        // randomized loads with random stalls
        for (int r = 0; r < 3; r++) begin
            fill_random($urandom_range(1, 6));
            build_model();
            snapshot();
            do_start(bq.size() / 4);
            send_stream($urandom_range(0, 2));
            wait_idle();
            compare_writes("rand");
            check("rand_done_count", 32'(done_cnt - base_done), 32'd1);
        end

        // full memory, incrementing bytes
        bq.delete();
        for (int k = 0; k < 256; k++) bq.push_back(8'(k));
        build_model();
        snapshot();
        do_start(64);
        send_stream(0);
        wait_idle();
        compare_writes("full");
        check("full_last_addr", got_addr[got_addr.size()-1], 32'h0000_00FC);
        check("full_done_count", 32'(done_cnt - base_done), 32'd1);

        // start held high across a 1-word session
        fill_random(1);
        build_model();
        snapshot();
        start     = 1'b1;
        num_words = 16'd1;
        @(negedge clock);
        send_stream(0);
        for (int t = 0; t < 20; t++) begin
            if (done === 1'b1) break;
            @(negedge clock);
        end
        check("held_done_seen", 32'(done), 32'd1);
        @(negedge clock);
        check("held_idle_hold", 32'(core_hold), 32'd0);
        compare_writes("held");
        check("held_done_count", 32'(done_cnt - base_done), 32'd1);
        @(negedge clock);
        check("held_restart_busy", 32'(busy), 32'd1);
        start = 1'b0;
        #2 reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // reset in the middle of a 3-word load
        fill_random(3);
        snapshot();
        do_start(3);
        for (int k = 0; k < 6; k++) send_byte(bq[k]);
        #2 reset = 1'b1;
        #1;
        check("abort_byte_ready", 32'(byte_ready), 32'd0);
        check("abort_mem_we", 32'(mem_we), 32'd0);
        check("abort_core_hold", 32'(core_hold), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_mem_addr", mem_addr, 32'd0);
        check("abort_mem_wdata", mem_wdata, 32'd0);
        check("abort_write_count", 32'(got_addr.size() - base_we), 32'd1);
        check("abort_write_addr", got_addr[base_we], 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        fill_random(1);
        build_model();
        snapshot();
        do_start(1);
        send_stream(0);
        wait_idle();
        compare_writes("after_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
